sdram_wbuf_fifo: RTL and testbench

SDRAM_WBUF_FIFO -- requirements
Module: sdram_wbuf_fifo

---
 rtl/sdram_wbuf_fifo_pkg.sv | 17 +
 rtl/sdram_wbuf_ram.sv | 32 +++
 rtl/sdram_wbuf_fifo.sv | 142 ++++++++++++++
 tb/tb_sdram_wbuf_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wbuf_fifo_pkg.sv
// Shared constants and entry layout for the SDRAM write buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_wbuf_fifo_pkg;

    localparam int SDRAM_ENTRY_W = 18;
    localparam int SDRAM_BE_W    = 2;
    localparam int SDRAM_DATA_W  = SDRAM_ENTRY_W - SDRAM_BE_W;
    localparam int SDRAM_WBUF_AW = 9;

    // One buffered write: byte enables above the data word
    typedef struct packed {
        logic [SDRAM_BE_W-1:0]   be;
        logic [SDRAM_DATA_W-1:0] dat;
    } wbuf_entry_t;

endpackage

// File: rtl/sdram_wbuf_ram.sv
// Simple dual-port storage for the write buffer, 2^AW x DW, no reset.
// Latency: registered read, data valid the cycle after re_i.
// Backpressure: none; read data holds while re_i is low.
module sdram_wbuf_ram #(
    parameter int AW = 9,
    parameter int DW = 18
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port; no reset so the array maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_wbuf_fifo.sv
// First-word-fall-through write buffer for the SDRAM path; optional hwm port via SDRAM_WBUF_HWM_EN.
// Latency: push into empty buffer shows on rd_valid two edges later; one pop per cycle sustained.
// Backpressure: wr_full rejects pushes (sets sticky ovf); head held stable until rd_ready.
module sdram_wbuf_fifo
    import sdram_wbuf_fifo_pkg::*;
#(
    parameter int AW = SDRAM_WBUF_AW
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    wr_req,
    input  logic [SDRAM_DATA_W-1:0] wr_data,
    input  logic [SDRAM_BE_W-1:0]   wr_be,
    output logic                    wr_full,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [SDRAM_DATA_W-1:0] rd_data,
    output logic [SDRAM_BE_W-1:0]   rd_be,
    output logic [AW:0]             level,
    output logic                    ovf
`ifdef SDRAM_WBUF_HWM_EN
    ,
    output logic [AW:0]             hwm
`endif
);

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;     // entries written but not yet read from RAM
    logic          s1_vld_q, s1_vld_d;       // RAM read data register holds a live entry
    logic          out_vld_q, out_vld_d;
    wbuf_entry_t   out_q, out_d;
    logic          ovf_q, ovf_d;
    wbuf_entry_t   wr_entry, ram_rdata;
    logic          push, pop, slot_free, issue, s1_move;

    sdram_wbuf_ram #(
        .AW (AW),
        .DW (SDRAM_ENTRY_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .re_i    (issue),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign wr_full  = (level_q == DEPTH);
    assign rd_valid = out_vld_q;
    assign rd_data  = out_q.dat;
    assign rd_be    = out_q.be;
    assign level    = level_q;
    assign ovf      = ovf_q;

    // Handshakes, read-pipeline advance and next-state; clr overrides everything but ovf
    always_comb begin
        wr_entry  = '{be: wr_be, dat: wr_data};
        push      = wr_req & ~wr_full & ~clr;
        pop       = out_vld_q & rd_ready & ~clr;
        slot_free = ~out_vld_q | pop;
        // RAM reads only see entries whose write edge has already passed
        issue     = ~clr & slot_free & (ram_cnt_q != '0);
        s1_move   = ~clr & slot_free & s1_vld_q;

        wptr_d    = push  ? wptr_q + PTR_ONE : wptr_q;
        rptr_d    = issue ? rptr_q + PTR_ONE : rptr_q;

        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        ram_cnt_d = ram_cnt_q;
        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + LVL_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - LVL_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        s1_vld_d  = issue ? 1'b1 : (s1_move ? 1'b0 : s1_vld_q);
        out_vld_d = s1_move ? 1'b1 : (pop ? 1'b0 : out_vld_q);
        out_d     = s1_move ? ram_rdata : out_q;
        ovf_d     = ovf_q | (wr_req & wr_full & ~clr);

        if (clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            ram_cnt_d = '0;
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ram_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ram_cnt_q <= ram_cnt_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SDRAM_WBUF_HWM_EN
    logic [AW:0] hwm_q;

    // Running maximum of level; clr drops level but never lowers the mark
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else if (level_d > hwm_q) begin
            hwm_q <= level_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sdram_wbuf_fifo.sv
// Randomised and directed bench for sdram_wbuf_fifo against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_wbuf_fifo;

    logic        clock = 1'b0;
    logic        reset_n, clr, wr_req, rd_ready;
    logic [15:0] wr_data, rd_data;
    logic [1:0]  wr_be, rd_be;
    logic        wr_full, rd_valid, ovf;
    logic [9:0]  level;
`ifdef SDRAM_WBUF_HWM_EN
    logic [9:0]  hwm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered contents and sticky overflow
    logic [17:0] mq[$];
    bit          m_ovf;

    sdram_wbuf_fifo dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (clr),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .wr_full  (wr_full),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_be    (rd_be),
        .level    (level),
        .ovf      (ovf)
`ifdef SDRAM_WBUF_HWM_EN
        ,
        .hwm      (hwm)
`endif
    );

    always #5 clock = ~clock;

    // One clock cycle: drive, sample pre-edge, advance model at the edge. Entered/left at posedge+1.
    task automatic cyc(input bit req, input logic [15:0] d, input logic [1:0] be,
                       input bit rdy, input bit c,
                       output bit popped, output logic [17:0] got, output logic [17:0] exp);
        bit full_b;
        wr_req = req; wr_data = d; wr_be = be; rd_ready = rdy; clr = c;
        #4;
        popped = rd_valid && rdy && !c;
        got    = {rd_be, rd_data};
        exp    = '0;
        full_b = (mq.size() == 512);
        @(posedge clock);
        if (c) begin
            mq.delete();
        end else begin
            if (popped) begin
                if (mq.size() > 0) exp = mq.pop_front();
                else               exp = ~got;
            end
            if (req) begin
                if (full_b) m_ovf = 1'b1;
                else        mq.push_back({be, d});
            end
        end
        #1;
        wr_req = 1'b0; clr = 1'b0;
    endtask

    task automatic hard_reset();
        reset_n = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_ready = 1'b0; wr_data = '0; wr_be = '0;
        mq.delete(); m_ovf = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_ready = 1'b0; wr_data = '0; wr_be = '0;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (level !== 10'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (ovf !== 1'b0 || wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags ovf=%b full=%b want 0 0", ovf, wr_full); end
        n_checks++; if ({rd_be, rd_data} !== 18'h0) begin n_fail++; $display("FAIL reset_head got %h want 0", {rd_be, rd_data}); end
`ifdef SDRAM_WBUF_HWM_EN
        n_checks++; if (hwm !== 10'd0) begin n_fail++; $display("FAIL reset_hwm got %0d want 0", hwm); end
`endif
        mq.delete(); m_ovf = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_empty_latency();
        bit p; logic [17:0] g, e;
        cyc(1, 16'h1234, 2'b01, 0, 0, p, g, e);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge0 rd_valid got %b want 0", rd_valid); end
        cyc(0, 16'h0, 2'b00, 0, 0, p, g, e);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1 rd_valid got %b want 0", rd_valid); end
        cyc(0, 16'h0, 2'b00, 0, 0, p, g, e);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge2 rd_valid got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 16'h1234 || rd_be !== 2'b01) begin n_fail++; $display("FAIL lat_head got %h/%b want 1234/01", rd_data, rd_be); end
        n_checks++; if (level !== 10'd1) begin n_fail++; $display("FAIL lat_level got %0d want 1", level); end
        cyc(0, 16'h0, 2'b00, 1, 0, p, g, e);
        n_checks++; if (!p || g !== e) begin n_fail++; $display("FAIL lat_pop got %h (popped %b) want %h", g, p, e); end
        n_checks++; if (level !== 10'd0) begin n_fail++; $display("FAIL lat_level_after got %0d want 0", level); end
    endtask

    task automatic test_stream();
        bit p; logic [17:0] g, e;
        int first = -1; int last = -1; int npop = 0;
        for (int c = 0; c < 60 && npop < 16; c++) begin
            cyc(c < 16, 16'(c + 1), 2'b11, 1, 0, p, g, e);
            if (p) begin
                n_checks++; if (g !== e) begin n_fail++; $display("FAIL stream_data got %h want %h", g, e); end
                if (first < 0) first = c;
                last = c;
                npop++;
            end
        end
        n_checks++; if (npop != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", npop); end
        n_checks++; if (first != 3) begin n_fail++; $display("FAIL stream_first got %0d want 3", first); end
        n_checks++; if (last - first != 15) begin n_fail++; $display("FAIL stream_bubble span got %0d want 15", last - first); end
        n_checks++; if (level !== 10'd0) begin n_fail++; $display("FAIL stream_level got %0d want 0", level); end
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        bit p; logic [17:0] g, e;
        for (int i = 0; i < n; i++) cyc(1, base + 16'(i), 2'(i), 0, 0, p, g, e);
    endtask

    task automatic drain(input string tag, input logic [15:0] forbidden, output int npop);
        bit p; logic [17:0] g, e;
        npop = 0;
        for (int c = 0; c < 700 && mq.size() > 0; c++) begin
            cyc(0, 16'h0, 2'b00, 1, 0, p, g, e);
            if (p) begin
                npop++;
                n_checks++;
                if (g !== e || g[15:0] === forbidden) begin n_fail++; $display("FAIL %s_data got %h want %h", tag, g, e); end
            end
        end
        n_checks++; if (mq.size() != 0) begin n_fail++; $display("FAIL %s_timeout left %0d want 0", tag, mq.size()); end
    endtask

    task automatic test_full_ovf();
        bit p; logic [17:0] g, e; int npop;
        fill(511, 16'h0000);
        n_checks++; if (wr_full !== 1'b0 || level !== 10'd511) begin n_fail++; $display("FAIL full_511 full=%b level=%0d want 0 511", wr_full, level); end
        fill(1, 16'd511);
        n_checks++; if (wr_full !== 1'b1 || level !== 10'd512 || ovf !== 1'b0) begin n_fail++; $display("FAIL full_512 full=%b level=%0d ovf=%b want 1 512 0", wr_full, level, ovf); end
        cyc(1, 16'hDEAD, 2'b11, 0, 0, p, g, e);
        n_checks++; if (wr_full !== 1'b1 || level !== 10'd512) begin n_fail++; $display("FAIL ovf_level full=%b level=%0d want 1 512", wr_full, level); end
        n_checks++; if (ovf !== m_ovf || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ovf); end
`ifdef SDRAM_WBUF_HWM_EN
        n_checks++; if (hwm !== 10'd512) begin n_fail++; $display("FAIL hwm_full got %0d want 512", hwm); end
`endif
        drain("full_drain", 16'hDEAD, npop);
        n_checks++; if (npop != 512 || level !== 10'd0) begin n_fail++; $display("FAIL full_drain_count pops=%0d level=%0d want 512 0", npop, level); end
        cyc(0, 16'h0, 2'b00, 0, 1, p, g, e);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_after_clr got %b want 1", ovf); end
    endtask

    task automatic test_full_simul();
        bit p; logic [17:0] g, e; int npop;
        hard_reset();
        fill(512, 16'h1000);
        cyc(0, 16'h0, 2'b00, 0, 0, p, g, e);
        cyc(1, 16'hBEEF, 2'b10, 1, 0, p, g, e);
        n_checks++; if (!p || g !== e) begin n_fail++; $display("FAIL simul_pop got %h (popped %b) want %h", g, p, e); end
        n_checks++; if (level !== 10'd511 || ovf !== 1'b1) begin n_fail++; $display("FAIL simul_state level=%0d ovf=%b want 511 1", level, ovf); end
        drain("simul_drain", 16'hBEEF, npop);
        n_checks++; if (npop != 511) begin n_fail++; $display("FAIL simul_count got %0d want 511", npop); end
    endtask

    task automatic test_wrap();
        bit p; logic [17:0] g, e;
        int pushes = 0; int pops = 0; int sz; bit req;
        hard_reset();
        for (int c = 0; c < 6000 && (pushes < 700 || mq.size() > 0); c++) begin
            req = (pushes < 700) && ($urandom_range(0, 3) != 0);
            sz  = mq.size();
            cyc(req, 16'($urandom), 2'($urandom), $urandom_range(0, 2) != 0, 0, p, g, e);
            if (req && sz < 512) pushes++;
            if (p) begin
                pops++;
                n_checks++; if (g !== e) begin n_fail++; $display("FAIL wrap_data got %h want %h", g, e); end
            end
            n_checks++; if (level !== 10'(mq.size())) begin n_fail++; $display("FAIL wrap_level got %0d want %0d", level, mq.size()); end
        end
        n_checks++; if (pushes != 700 || pops != 700) begin n_fail++; $display("FAIL wrap_count pushes=%0d pops=%0d want 700 700", pushes, pops); end
    endtask

    task automatic test_flush();
        bit p; logic [17:0] g, e; int npop;
        hard_reset();
        fill(5, 16'h2000);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 2'b00, 0, 0, p, g, e);
        n_checks++; if (rd_valid !== 1'b1 || level !== 10'd5) begin n_fail++; $display("FAIL flush_pre valid=%b level=%0d want 1 5", rd_valid, level); end
        cyc(1, 16'h5555, 2'b11, 1, 1, p, g, e);
        n_checks++; if (level !== 10'd0 || rd_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL flush_post level=%0d valid=%b ovf=%b want 0 0 0", level, rd_valid, ovf); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0, 2'b00, 1, 0, p, g, e);
            n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_inflight cycle %0d rd_valid got %b want 0", i, rd_valid); end
        end
        cyc(1, 16'h0A0A, 2'b10, 0, 0, p, g, e);
        drain("flush_after", 16'h5555, npop);
        n_checks++; if (npop != 1) begin n_fail++; $display("FAIL flush_after_count got %0d want 1", npop); end
    endtask

    task automatic test_async_reset();
        bit p; logic [17:0] g, e; int npop;
        hard_reset();
        fill(513, 16'hF000);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0 || level !== 10'd0 || wr_full !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL areset_flags valid=%b level=%0d full=%b ovf=%b want 0", rd_valid, level, wr_full, ovf); end
        n_checks++; if ({rd_be, rd_data} !== 18'h0) begin n_fail++; $display("FAIL areset_head got %h want 0", {rd_be, rd_data}); end
`ifdef SDRAM_WBUF_HWM_EN
        n_checks++; if (hwm !== 10'd0) begin n_fail++; $display("FAIL areset_hwm got %0d want 0", hwm); end
`endif
        mq.delete(); m_ovf = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc(1, 16'h0777, 2'b01, 0, 0, p, g, e);
        n_checks++; if (level !== 10'd1) begin n_fail++; $display("FAIL first_push level got %0d want 1", level); end
        drain("first_push", 16'hF000, npop);
        n_checks++; if (npop != 1) begin n_fail++; $display("FAIL first_push_count got %0d want 1", npop); end
    endtask

    initial begin
        test_reset();
        test_empty_latency();
        test_stream();
        test_full_ovf();
        test_full_simul();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
